nibble_prog_loader: RTL and testbench

- Writer/encoder side of the Nibble instruction path.
- Accepts decoded instruction fields (op, x, y, addr) over a valid/ready handshake and packs each set into the 24-bit instruction word format that the fetch/decode stage unpacks.
- Writes the packed words into program memory at sequential addresses.
- Holds the CPU (PC/fetch) in stall while a program is being loaded.

---
 rtl/nibble_prog_loader_if.sv | 27 ++
 rtl/nibble_prog_loader.sv | 94 +++++++++
 tb/tb_nibble_prog_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/nibble_prog_loader_if.sv
// Handshake and program-memory write bus between an instruction source,
// the loader and program memory.
interface nibble_prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 24
);
  logic              in_valid;
  logic              in_last;
  logic [2:0]        in_op;
  logic [7:0]        in_x;
  logic [7:0]        in_y;
  logic [3:0]        in_addr;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output in_valid, in_last, in_op, in_x, in_y, in_addr,
    input  in_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_last, in_op, in_x, in_y, in_addr,
    output in_ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/nibble_prog_loader.sv
// Packs decoded instruction fields into 24-bit words and writes them to
// program memory at sequential addresses, stalling the CPU while loading.
module nibble_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  nibble_prog_loader_if.slave  bus,
  output logic                 cpu_hold,
  output logic                 done,
  output logic [ADDR_W:0]      word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wptr_reg;
  logic [ADDR_W:0]   word_count_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic              accept;
  logic              in_ready_int;
  logic              cpu_hold_int;
  logic              done_int;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A start pulse always wins over a beat presented in the same cycle.
  always_comb begin
    state_next   = state_reg;
    in_ready_int = 1'b0;
    cpu_hold_int = 1'b0;
    done_int     = 1'b0;
    accept       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        cpu_hold_int = 1'b1;
        in_ready_int = !start;
        accept       = bus.in_valid && !start;
        if (!start && accept &&
            (bus.in_last || wptr_reg == ADDR_W'(DEPTH - 1)))
          state_next = DONE;
      end
      DONE: begin
        done_int = 1'b1;
        if (start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_reg       <= '0;
      word_count_reg <= '0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
    end else begin
      mem_we_reg <= accept;
      if (start) begin
        wptr_reg       <= '0;
        word_count_reg <= '0;
      end else if (accept) begin
        wptr_reg       <= wptr_reg + 1'b1;
        word_count_reg <= word_count_reg + 1'b1;
      end
      // Address/data hold their last value whenever no write is issued.
      if (accept) begin
        mem_addr_reg <= wptr_reg;
        mem_data_reg <= DATA_W'({bus.in_op, bus.in_x, bus.in_y, bus.in_addr, 1'b0});
      end
    end
  end

  assign bus.in_ready = in_ready_int;
  assign bus.mem_we   = mem_we_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_data = mem_data_reg;
  assign cpu_hold     = cpu_hold_int;
  assign done         = done_int;
  assign word_count   = word_count_reg;

endmodule

// File: tb/tb_nibble_prog_loader.sv
// Randomized and directed checks of the program loader against a
// behavioural model of the load session.
module tb_nibble_prog_loader;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;

  logic       clock;
  logic       reset;
  logic       start;
  logic       cpu_hold;
  logic       done;
  logic [4:0] word_count;

  nibble_prog_loader_if #(.ADDR_W(4), .DATA_W(24)) bus ();

  nibble_prog_loader #(.ADDR_W(4), .DEPTH(16), .DATA_W(24)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .bus        (bus.slave),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .word_count (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model of one load session
  int exp_mode  = M_IDLE;
  int exp_wptr  = 0;
  int exp_count = 0;
  int exp_we    = 0;
  int exp_addr  = 0;
  int exp_data  = 0;

  task automatic cmp(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_mode  = M_IDLE;
      exp_wptr  = 0;
      exp_count = 0;
      exp_we    = 0;
      exp_addr  = 0;
      exp_data  = 0;
    end else begin
      if (exp_mode == M_LOAD && !start && bus.in_valid) begin
        exp_we    = 1;
        exp_addr  = exp_wptr;
        exp_data  = int'(bus.in_op) * 2097152 + int'(bus.in_x) * 8192 +
                    int'(bus.in_y) * 32 + int'(bus.in_addr) * 2;
        exp_count = exp_count + 1;
        if (bus.in_last || exp_wptr == 15) exp_mode = M_DONE;
        exp_wptr  = (exp_wptr + 1) % 16;
      end else begin
        exp_we = 0;
      end
      if (start) begin
        exp_mode  = M_LOAD;
        exp_wptr  = 0;
        exp_count = 0;
      end
    end
  end

  // Single compare process: every cycle while out of reset
  always @(negedge clock) begin
    if (reset) begin
      cmp("in_ready",   int'(bus.in_ready), int'(exp_mode == M_LOAD && !start));
      cmp("cpu_hold",   int'(cpu_hold),     int'(exp_mode == M_LOAD));
      cmp("done",       int'(done),         int'(exp_mode == M_DONE));
      cmp("word_count", int'(word_count),   exp_count);
      cmp("mem_we",     int'(bus.mem_we),   exp_we);
      cmp("mem_addr",   int'(bus.mem_addr), exp_addr);
      cmp("mem_data",   int'(bus.mem_data), exp_data);
    end
  end

  task automatic put(input logic s, input logic v, input logic l,
                     input logic [2:0] op, input logic [7:0] x,
                     input logic [7:0] y, input logic [3:0] a);
    start        = s;
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_op    = op;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_addr  = a;
  endtask

  task automatic put_rand(input logic s, input logic v, input logic l);
    put(s, v, l, 3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    put(0, 0, 0, 3'd0, 8'd0, 8'd0, 4'd0);
    #1;
    cmp("rst_in_ready",   int'(bus.in_ready), 0);
    cmp("rst_mem_we",     int'(bus.mem_we),   0);
    cmp("rst_mem_data",   int'(bus.mem_data), 0);
    cmp("rst_word_count", int'(word_count),   0);
    cmp("rst_cpu_hold",   int'(cpu_hold),     0);
    repeat (3) cyc();
    reset = 1'b1;
    cyc();

    // Two-beat program with hand-packed words
    put(1, 0, 0, 3'd0, 8'd0, 8'd0, 4'd0); cyc();
    put(0, 1, 0, 3'b101, 8'h3C, 8'hA5, 4'h9); cyc();
    cmp("ex1_we",   int'(bus.mem_we),   1);
    cmp("ex1_addr", int'(bus.mem_addr), 0);
    cmp("ex1_data", int'(bus.mem_data), 32'hA794B2);
    put(0, 1, 1, 3'b010, 8'hFF, 8'h00, 4'hF); cyc();
    cmp("ex2_addr", int'(bus.mem_addr), 1);
    cmp("ex2_data", int'(bus.mem_data), 32'h5FE01E);
    put(0, 0, 0, 3'd0, 8'd0, 8'd0, 4'd0); cyc();
    cmp("ex_done",  int'(done),       1);
    cmp("ex_hold",  int'(cpu_hold),   0);
    cmp("ex_count", int'(word_count), 2);

    // Reload from DONE, then a full 16-word load
    put(1, 0, 0, 3'd0, 8'd0, 8'd0, 4'd0); cyc();
    cmp("reload_done", int'(done),     0);
    cmp("reload_hold", int'(cpu_hold), 1);
    for (int i = 0; i < 16; i++) begin
      put_rand(0, 1, 0); cyc();
      cmp("full_addr", int'(bus.mem_addr), i);
      cmp("full_we",   int'(bus.mem_we),   1);
    end
    cmp("full_done",  int'(done),         1);
    cmp("full_count", int'(word_count),   16);
    cmp("full_ready", int'(bus.in_ready), 0);
    put_rand(0, 1, 0); cyc();
    cmp("full_17th_we", int'(bus.mem_we), 0);

    // Abort after five writes with a beat offered alongside start
    put(1, 0, 0, 3'd0, 8'd0, 8'd0, 4'd0); cyc();
    for (int i = 0; i < 5; i++) begin
      put_rand(0, 1, 0); cyc();
    end
    cmp("abort_pre_count", int'(word_count), 5);
    put_rand(1, 1, 0); cyc();
    cmp("abort_we",    int'(bus.mem_we), 0);
    cmp("abort_count", int'(word_count), 0);
    put_rand(0, 1, 0); cyc();
    cmp("abort_addr",   int'(bus.mem_addr), 0);
    cmp("abort_count1", int'(word_count),   1);

    // Alternating in_valid: writes contiguous, one cycle after accept
    for (int i = 0; i < 8; i++) begin
      put_rand(0, logic'(i % 2 == 0), 0); cyc();
    end

    // Asynchronous reset while a write is on the bus
    put(1, 0, 0, 3'd0, 8'd0, 8'd0, 4'd0); cyc();
    put_rand(0, 1, 0); cyc();
    cmp("mid_we_before", int'(bus.mem_we), 1);
    reset = 1'b0;
    #1;
    cmp("mid_we",    int'(bus.mem_we),   0);
    cmp("mid_hold",  int'(cpu_hold),     0);
    cmp("mid_ready", int'(bus.in_ready), 0);
    cmp("mid_done",  int'(done),         0);
    cmp("mid_count", int'(word_count),   0);
    put_rand(0, 1, 0);
    cyc();
    reset = 1'b1;
    cyc();
    cmp("post_rst_hold", int'(cpu_hold),   0);
    cmp("post_rst_we",   int'(bus.mem_we), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      put_rand(logic'($urandom_range(0, 99) < 4),
               logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 99) < 8));
      cyc();
    end

    put(0, 0, 0, 3'd0, 8'd0, 8'd0, 4'd0);
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
